// File: rtl/req_encoder4to2.sv
// Sequential 4-to-2 request encoder: captures multi-hot request pulses and
// presents them one at a time as binary codes over a valid/ready handshake.
module req_encoder4to2 #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] out_code,
    output logic [3:0] out_onehot,
    output logic [3:0] pending,
    output logic       overrun,
    input  logic       clr_overrun
);

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic [W-1:0] ptr;
    logic         load;
    logic [N-1:0] presented_mask;
    logic [N-1:0] req_eff;
    logic [N-1:0] cand;
    logic [W-1:0] sel;
    logic [W-1:0] idx;
    logic         found;
    logic         overrun_set;

    logic         out_valid_n;
    logic [W-1:0] out_code_n;
    logic [N-1:0] pending_n;
    logic [W-1:0] ptr_n;
    logic         overrun_n;

    // Candidate selection and next-state computation
    always_comb begin
        load           = !out_valid || out_ready;
        presented_mask = out_valid ? (N'(1) << out_code) : '0;
        // A request for the code held under stall merges into it rather than queueing a duplicate
        req_eff        = load ? req : (req & ~presented_mask);
        cand           = pending | req_eff;
        sel            = '0;
        idx            = '0;
        found          = 1'b0;

        if (RR) begin
            for (int i = 0; i < int'(N); i++) begin
                idx = ptr + W'(i);
                if (!found && cand[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (cand[i]) begin
                    sel = W'(i);
                end
            end
        end

        overrun_set = (|(req & pending)) || (!load && (|(req & presented_mask)));

        out_valid_n = out_valid;
        out_code_n  = out_code;
        pending_n   = pending;
        ptr_n       = ptr;

        if (load) begin
            if (|cand) begin
                out_valid_n = 1'b1;
                out_code_n  = sel;
                pending_n   = cand & ~(N'(1) << sel);
                ptr_n       = sel + W'(1);
            end else begin
                out_valid_n = 1'b0;
                pending_n   = '0;
            end
        end else begin
            pending_n = pending | req_eff;
        end

        if (overrun_set) begin
            overrun_n = 1'b1;
        end else if (clr_overrun) begin
            overrun_n = 1'b0;
        end else begin
            overrun_n = overrun;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            pending   <= '0;
            ptr       <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= out_valid_n;
            out_code  <= out_code_n;
            pending   <= pending_n;
            ptr       <= ptr_n;
            overrun   <= overrun_n;
        end
    end

    assign out_onehot = out_valid ? (N'(1) << out_code) : '0;

endmodule

// File: tb/tb_req_encoder4to2.sv
// Directed bench for req_encoder4to2: one round-robin and one fixed-priority
// instance share the same stimulus.
module tb_req_encoder4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       clr_overrun;

    logic       rr_valid, fp_valid;
    logic [1:0] rr_code, fp_code;
    logic [3:0] rr_onehot, fp_onehot;
    logic [3:0] rr_pending, fp_pending;
    logic       rr_overrun, fp_overrun;

    int checks = 0;
    int failures = 0;

    req_encoder4to2 #(.RR(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(rr_valid), .out_code(rr_code), .out_onehot(rr_onehot),
        .pending(rr_pending), .overrun(rr_overrun), .clr_overrun(clr_overrun)
    );

    req_encoder4to2 #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(fp_valid), .out_code(fp_code), .out_onehot(fp_onehot),
        .pending(fp_pending), .overrun(fp_overrun), .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1; clr_overrun = 1'b0;
        step(); step();
        check("rst_valid", 8'(rr_valid), 8'd0);
        check("rst_code", 8'(rr_code), 8'd0);
        check("rst_pending", 8'(rr_pending), 8'd0);
        check("rst_overrun", 8'(rr_overrun), 8'd0);
        check("rst_fp_valid", 8'(fp_valid), 8'd0);

        rst_n = 1'b1; req = 4'b0000;
        step();
        check("idle_valid", 8'(rr_valid), 8'd0);
        check("idle_onehot", 8'(rr_onehot), 8'd0);

        // Single request
        req = 4'b0100;
        step(); req = 4'b0000;
        check("single_valid", 8'(rr_valid), 8'd1);
        check("single_code", 8'(rr_code), 8'd2);
        check("single_onehot", 8'(rr_onehot), 8'h04);
        step();
        check("single_done", 8'(rr_valid), 8'd0);
        check("single_hold_code", 8'(rr_code), 8'd2);
        check("single_done_onehot", 8'(rr_onehot), 8'd0);

        // Round-robin from a fresh pointer
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b1111;
        step(); req = 4'b0000;
        check("rr0_code", 8'(rr_code), 8'd0);
        check("rr0_pending", 8'(rr_pending), 8'h0e);
        step();
        check("rr1_code", 8'(rr_code), 8'd1);
        step();
        check("rr2_code", 8'(rr_code), 8'd2);
        step();
        check("rr3_code", 8'(rr_code), 8'd3);
        check("rr3_valid", 8'(rr_valid), 8'd1);
        req = 4'b1001;
        step(); req = 4'b0000;
        check("rrwrap_code0", 8'(rr_code), 8'd0);
        check("rrwrap_pending", 8'(rr_pending), 8'h08);
        check("rrwrap_no_overrun", 8'(rr_overrun), 8'd0);
        step();
        check("rrwrap_code3", 8'(rr_code), 8'd3);
        step();
        check("rr_drained", 8'(rr_valid), 8'd0);
        check("fp_drained", 8'(fp_valid), 8'd0);

        // Fixed priority
        req = 4'b1011;
        step(); req = 4'b0000;
        check("fp_code3", 8'(fp_code), 8'd3);
        check("fp_onehot3", 8'(fp_onehot), 8'h08);
        step();
        check("fp_code1", 8'(fp_code), 8'd1);
        step();
        check("fp_code0", 8'(fp_code), 8'd0);
        step();
        check("fp_done", 8'(fp_valid), 8'd0);

        // Backpressure
        out_ready = 1'b0; req = 4'b0011;
        step(); req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 8'(rr_valid), 8'd1);
            check("bp_code", 8'(rr_code), 8'd0);
            check("bp_pending", 8'(rr_pending), 8'h02);
            if (i < 4) step();
        end
        out_ready = 1'b1;
        step();
        check("bp_code1", 8'(rr_code), 8'd1);
        check("bp_pending_empty", 8'(rr_pending), 8'd0);
        step();
        check("bp_done", 8'(rr_valid), 8'd0);

        // Overrun and coalescing under stall
        out_ready = 1'b0; req = 4'b0010;
        step(); req = 4'b0000;
        check("ov_present", 8'(rr_code), 8'd1);
        check("ov_not_yet", 8'(rr_overrun), 8'd0);
        step();
        req = 4'b0010;
        step(); req = 4'b0000;
        check("ov_set", 8'(rr_overrun), 8'd1);
        check("ov_no_dup_pending", 8'(rr_pending), 8'd0);
        out_ready = 1'b1;
        step();
        check("ov_once", 8'(rr_valid), 8'd0);
        step();
        check("ov_still_once", 8'(rr_valid), 8'd0);
        check("ov_sticky", 8'(rr_overrun), 8'd1);
        clr_overrun = 1'b1;
        step(); clr_overrun = 1'b0;
        check("ov_cleared", 8'(rr_overrun), 8'd0);

        // Request in the same cycle its code is accepted is a fresh event
        out_ready = 1'b0; req = 4'b0010;
        step(); req = 4'b0000;
        out_ready = 1'b1; req = 4'b0010;
        step(); req = 4'b0000;
        check("rearm_valid", 8'(rr_valid), 8'd1);
        check("rearm_code", 8'(rr_code), 8'd1);
        check("rearm_no_overrun", 8'(rr_overrun), 8'd0);
        step();
        check("rearm_done", 8'(rr_valid), 8'd0);

        // Set wins over a coincident clear
        out_ready = 1'b0; req = 4'b0100;
        step();
        clr_overrun = 1'b1;
        step();
        req = 4'b0000;
        check("setwins", 8'(rr_overrun), 8'd1);
        step(); clr_overrun = 1'b0;
        check("clr_after_setwins", 8'(rr_overrun), 8'd0);
        out_ready = 1'b1;
        step();
        check("final_idle", 8'(rr_valid), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
